// File: rtl/imm_decode_stage_if.sv
// Fetch-side and issue-side handshake bundle for imm_decode_stage.
// The slave modport is the stage; the master modport is whatever drives it.
interface imm_decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     in_instr_i;
    logic [XLEN-1:0] in_pc_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] out_imm_o;
    logic [2:0]      out_fmt_o;
    logic [XLEN-1:0] out_pc_o;
    logic [31:0]     out_instr_o;
    logic            out_unknown_o;
    logic [CW-1:0]   count_o;

    modport master (
        output in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_imm_o, out_fmt_o, out_pc_o,
               out_instr_o, out_unknown_o, count_o
    );

    modport slave (
        input  in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        output in_ready_o, out_valid_o, out_imm_o, out_fmt_o, out_pc_o,
               out_instr_o, out_unknown_o, count_o
    );
endinterface

// File: rtl/imm_decode_stage.sv
// Registered RV immediate-decode stage with a DEPTH-entry output buffer.
// Define IMM_CSR_EN to decode CSR immediate forms (CSRRWI/CSRRSI/CSRRCI).
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input logic              clk_i,
    input logic              rst_i,
    imm_decode_stage_if.slave bus
);
    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and in_ready_o is a flop with no path from out_ready_i.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_CSR  = 3'd6
    } fmt_e;

    logic [31:0]     w_instr;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    fmt_e            w_fmt;
    logic            w_unknown;

    assign w_instr = bus.in_instr_i;

    always_comb begin
        w_imm32   = '0;
        w_fmt     = FMT_NONE;
        w_unknown = 1'b0;
        case (w_instr[6:0])
            7'b0110111, 7'b0010111: begin
                w_fmt   = FMT_U;
                w_imm32 = {w_instr[31:12], 12'b0};
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_fmt   = FMT_I;
                w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
            end
            7'b0100011: begin
                w_fmt   = FMT_S;
                w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            end
            7'b1100011: begin
                w_fmt   = FMT_B;
                w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                           w_instr[30:25], w_instr[11:8], 1'b0};
            end
            7'b1101111: begin
                w_fmt   = FMT_J;
                w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                           w_instr[20], w_instr[30:21], 1'b0};
            end
            7'b0110011: begin
                w_fmt = FMT_NONE;
            end
            7'b1110011: begin
`ifdef IMM_CSR_EN
                // funct3[2] selects the zimm forms; rs1 field carries the immediate
                if (w_instr[14]) begin
                    w_fmt   = FMT_CSR;
                    w_imm32 = {27'b0, w_instr[19:15]};
                end
`else
                w_fmt = FMT_NONE;
`endif
            end
            default: w_unknown = 1'b1;
        endcase
    end

    // Bit 31 of the 32-bit result already carries the sign (0 for zimm)
    generate
        if (XLEN == 32) begin : g_ext32
            assign w_imm = w_imm32;
        end else begin : g_extw
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end
    endgenerate

    logic [XLEN-1:0] r_imm   [DEPTH];
    logic [2:0]      r_fmt   [DEPTH];
    logic [XLEN-1:0] r_pc    [DEPTH];
    logic [31:0]     r_instr [DEPTH];
    logic            r_unk   [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_in_ready;

    logic            w_out_valid;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count_nxt;

    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid_i && r_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready_i;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
            for (int k = 0; k < DEPTH; k++) begin
                r_imm[k]   <= '0;
                r_fmt[k]   <= FMT_NONE;
                r_pc[k]    <= '0;
                r_instr[k] <= '0;
                r_unk[k]   <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_imm[r_wr_ptr]   <= w_imm;
                r_fmt[r_wr_ptr]   <= w_fmt;
                r_pc[r_wr_ptr]    <= bus.in_pc_i;
                r_instr[r_wr_ptr] <= w_instr;
                r_unk[r_wr_ptr]   <= w_unknown;
                r_wr_ptr          <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != CW'(DEPTH));
        end
    end

    assign bus.in_ready_o    = r_in_ready;
    assign bus.out_valid_o   = w_out_valid;
    assign bus.out_imm_o     = r_imm[r_rd_ptr];
    assign bus.out_fmt_o     = r_fmt[r_rd_ptr];
    assign bus.out_pc_o      = r_pc[r_rd_ptr];
    assign bus.out_instr_o   = r_instr[r_rd_ptr];
    assign bus.out_unknown_o = r_unk[r_rd_ptr];
    assign bus.count_o       = r_count;
endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: a 32-bit and a 64-bit instance share
// one stimulus stream; each has its own expected queue.
module tb_imm_decode_stage;
  localparam int EW = 64 + 64 + 32 + 3 + 1;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        unk;
  } vec_t;

  logic clk;
  logic rst;
  logic in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic out_ready;
  logic rnd_rdy;
  logic [31:0] cur_imm;
  logic [2:0] cur_fmt;
  logic cur_unk;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[$];
  logic [EW-1:0] exp32_q[$];
  logic [EW-1:0] exp64_q[$];

  imm_decode_stage_if #(.XLEN(32), .DEPTH(2)) b32 ();
  imm_decode_stage_if #(.XLEN(64), .DEPTH(2)) b64 ();

  assign b32.in_valid_i  = in_valid;
  assign b32.in_instr_i  = in_instr;
  assign b32.in_pc_i     = in_pc[31:0];
  assign b32.out_ready_i = out_ready;
  assign b64.in_valid_i  = in_valid;
  assign b64.in_instr_i  = in_instr;
  assign b64.in_pc_i     = in_pc;
  assign b64.out_ready_i = out_ready;

  imm_decode_stage #(.XLEN(32), .DEPTH(2)) u_dut32 (.clk_i(clk), .rst_i(rst), .bus(b32));
  imm_decode_stage #(.XLEN(64), .DEPTH(2)) u_dut64 (.clk_i(clk), .rst_i(rst), .bus(b64));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void add_vec(input logic [31:0] instr, input logic [31:0] imm,
                                  input logic [2:0] fmt, input logic unk);
    vec_t v;
    v.instr = instr;
    v.imm = imm;
    v.fmt = fmt;
    v.unk = unk;
    vecs.push_back(v);
  endfunction

  // scoreboard: pop on output handshake, push on input handshake
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst) begin
      check_eq("count32", 64'(b32.count_o), 64'(exp32_q.size()));
      check_eq("count64", 64'(b64.count_o), 64'(exp64_q.size()));
      if (b32.out_valid_o && b32.out_ready_i) begin
        if (exp32_q.size() == 0) check_eq("sb32_extra", 64'd1, 64'd0);
        else begin
          e = exp32_q.pop_front();
          check_eq("imm32", {32'b0, b32.out_imm_o}, e[163:100]);
          check_eq("pc32", {32'b0, b32.out_pc_o}, e[99:36]);
          check_eq("instr32", 64'(b32.out_instr_o), 64'(e[35:4]));
          check_eq("fmt32", 64'(b32.out_fmt_o), 64'(e[3:1]));
          check_eq("unk32", 64'(b32.out_unknown_o), 64'(e[0]));
        end
      end
      if (b64.out_valid_o && b64.out_ready_i) begin
        if (exp64_q.size() == 0) check_eq("sb64_extra", 64'd1, 64'd0);
        else begin
          e = exp64_q.pop_front();
          check_eq("imm64", b64.out_imm_o, e[163:100]);
          check_eq("pc64", b64.out_pc_o, e[99:36]);
          check_eq("instr64", 64'(b64.out_instr_o), 64'(e[35:4]));
          check_eq("fmt64", 64'(b64.out_fmt_o), 64'(e[3:1]));
          check_eq("unk64", 64'(b64.out_unknown_o), 64'(e[0]));
        end
      end
      if (b32.in_valid_i && b32.in_ready_o)
        exp32_q.push_back({32'b0, cur_imm, 32'b0, in_pc[31:0], in_instr, cur_fmt, cur_unk});
      if (b64.in_valid_i && b64.in_ready_o)
        exp64_q.push_back({{32{cur_imm[31]}}, cur_imm, in_pc, in_instr, cur_fmt, cur_unk});
    end
  end

  // driver tasks (entered and left at posedge + 1)
  task automatic set_in(input int idx, input logic [63:0] pc);
    in_instr = vecs[idx].instr;
    in_pc = pc;
    cur_imm = vecs[idx].imm;
    cur_fmt = vecs[idx].fmt;
    cur_unk = vecs[idx].unk;
  endtask

  task automatic push_vec(input int idx, input logic [63:0] pc);
    bit accepted = 0;
    set_in(idx, pc);
    in_valid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (b32.in_ready_o) begin
        accepted = 1;
        break;
      end
      @(posedge clk); #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    if (!accepted) check_eq("push_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (exp32_q.size() == 0 && exp64_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check_eq("drain32", 64'(exp32_q.size()), 64'd0);
    check_eq("drain64", 64'(exp64_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] rnd_pc();
    return {$urandom, $urandom & 32'hFFFF_FFFC};
  endfunction

  initial begin
    add_vec(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
    add_vec(32'h12345037, 32'h12345000, 3'd4, 1'b0);
    add_vec(32'h0020A423, 32'h00000008, 3'd2, 1'b0);
    add_vec(32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0);
    add_vec(32'h0000007F, 32'h00000000, 3'd0, 1'b1);
`ifdef IMM_CSR_EN
    add_vec(32'h3007D073, 32'h0000000F, 3'd6, 1'b0);
`else
    add_vec(32'h3007D073, 32'h00000000, 3'd0, 1'b0);
`endif
    add_vec(32'h80000037, 32'h80000000, 3'd4, 1'b0);
    add_vec(32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0);
    add_vec(32'h00208463, 32'h00000008, 3'd3, 1'b0);
    add_vec(32'h00412083, 32'h00000004, 3'd1, 1'b0);
    add_vec(32'h000080E7, 32'h00000000, 3'd1, 1'b0);
    add_vec(32'h80000017, 32'h80000000, 3'd4, 1'b0);
    add_vec(32'hFE002FA3, 32'hFFFFFFFF, 3'd2, 1'b0);
    add_vec(32'h00000073, 32'h00000000, 3'd0, 1'b0);
    add_vec(32'h30002073, 32'h00000000, 3'd0, 1'b0);
    add_vec(32'h00000033, 32'h00000000, 3'd0, 1'b0);

    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc = '0;
    out_ready = 1'b0;
    rnd_rdy = 1'b0;
    cur_imm = '0;
    cur_fmt = '0;
    cur_unk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid32", 64'(b32.out_valid_o), 64'd0);
    check_eq("rst_ready32", 64'(b32.in_ready_o), 64'd1);
    check_eq("rst_count32", 64'(b32.count_o), 64'd0);
    check_eq("rst_imm32", 64'(b32.out_imm_o), 64'd0);
    check_eq("rst_fmt32", 64'(b32.out_fmt_o), 64'd0);
    check_eq("rst_pc32", 64'(b32.out_pc_o), 64'd0);
    check_eq("rst_instr32", 64'(b32.out_instr_o), 64'd0);
    check_eq("rst_unk32", 64'(b32.out_unknown_o), 64'd0);
    check_eq("rst_valid64", 64'(b64.out_valid_o), 64'd0);
    check_eq("rst_imm64", b64.out_imm_o, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single push into an empty buffer: visible one cycle later
    out_ready = 1'b1;
    push_vec(0, rnd_pc());
    check_eq("lat_valid32", 64'(b32.out_valid_o), 64'd1);
    check_eq("lat_valid64", 64'(b64.out_valid_o), 64'd1);
    for (int i = 1; i <= 3; i++) push_vec(i, rnd_pc());
    drain();

    // backpressure: fill, block a third push, then pop one
    @(posedge clk); #1;
    out_ready = 1'b0;
    push_vec(1, rnd_pc());
    push_vec(2, rnd_pc());
    check_eq("full_ready", 64'(b32.in_ready_o), 64'd0);
    check_eq("full_count", 64'(b32.count_o), 64'd2);
    check_eq("head_instr", 64'(b32.out_instr_o), 64'(vecs[1].instr));
    set_in(3, rnd_pc());
    in_valid = 1'b1;
    @(negedge clk);
    check_eq("full_block", 64'(b32.in_ready_o), 64'd0);
    @(posedge clk); #1;
    check_eq("hold_instr", 64'(b32.out_instr_o), 64'(vecs[1].instr));
    check_eq("hold_imm", 64'(b32.out_imm_o), 64'(vecs[1].imm));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("pop_count", 64'(b32.count_o), 64'd1);
    check_eq("pop_ready", 64'(b32.in_ready_o), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("refill_count", 64'(b32.count_o), 64'd2);
    drain();

    // every table entry once, back to back
    for (int i = 0; i < vecs.size(); i++) push_vec(i, rnd_pc());
    drain();

    // asynchronous reset with two entries held
    out_ready = 1'b0;
    push_vec(7, rnd_pc());
    push_vec(8, rnd_pc());
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid32", 64'(b32.out_valid_o), 64'd0);
    check_eq("arst_count32", 64'(b32.count_o), 64'd0);
    check_eq("arst_ready32", 64'(b32.in_ready_o), 64'd1);
    check_eq("arst_valid64", 64'(b64.out_valid_o), 64'd0);
    check_eq("arst_count64", 64'(b64.count_o), 64'd0);
    exp32_q.delete();
    exp64_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    push_vec(9, rnd_pc());
    check_eq("post_rst_lat", 64'(b32.out_valid_o), 64'd1);
    drain();

    // random order with random backpressure and gaps
    rnd_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      push_vec($urandom_range(0, vecs.size() - 1), rnd_pc());
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    rnd_rdy = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
